// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared constants and width helpers for the vertical bicubic weight accumulator.
package bicubic_pkg;
    localparam int PIXEL_MAX      = 255;
    localparam int WEIGHT_W       = 4;
    localparam int FRAC_SHIFT_DEF = 8;

    function automatic int term_width(input int pw);
        return pw + WEIGHT_W;
    endfunction

    // Four terms of magnitude < 2^(pw+3) sum to < 2^(pw+5); one more bit for the sign.
    function automatic int sum_width(input int pw);
        return pw + WEIGHT_W + 2;
    endfunction
endpackage

// File: rtl/bicubic_sm_term.sv
// bicubic_sm_term: one sign-magnitude inner product times one sign-magnitude vertical weight.
module bicubic_sm_term
    import bicubic_pkg::*;
#(
    parameter int PRODUCT_WIDTH = 32,
    localparam int TW = term_width(PRODUCT_WIDTH)
) (
    input  logic [PRODUCT_WIDTH-2:0] i_ip,
    input  logic                     i_ip_sign,
    input  logic [WEIGHT_W-1:0]      i_w,
    input  logic                     i_w_sign,
    output logic signed [TW-1:0]     o_term
);
    logic [TW-1:0] w_mag;

    assign w_mag  = TW'(i_ip) * TW'(i_w);
    assign o_term = (i_ip_sign ^ i_w_sign) ? -w_mag : w_mag;
endmodule

// File: rtl/bicubic_vweight_accum.sv
// bicubic_vweight_accum: 3-stage elastic pipeline applying four signed vertical weights,
// then rounding, shifting and clamping to an 8-bit pixel with a saturating clamp counter.
module bicubic_vweight_accum
    import bicubic_pkg::*;
#(
    parameter int PRODUCT_WIDTH = 32,
    parameter int FRAC_SHIFT    = FRAC_SHIFT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WEIGHT_W-1:0]      v1,
    input  logic [WEIGHT_W-1:0]      v2,
    input  logic [WEIGHT_W-1:0]      v3,
    input  logic [WEIGHT_W-1:0]      v4,
    input  logic [3:0]               v_sign,
    input  logic [PRODUCT_WIDTH-2:0] ip1,
    input  logic [PRODUCT_WIDTH-2:0] ip2,
    input  logic [PRODUCT_WIDTH-2:0] ip3,
    input  logic [PRODUCT_WIDTH-2:0] ip4,
    input  logic                     ip_sign1,
    input  logic                     ip_sign2,
    input  logic                     ip_sign3,
    input  logic                     ip_sign4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               pixel,
    output logic [15:0]              clamp_cnt
);
    localparam int TW = term_width(PRODUCT_WIDTH);
    localparam int SW = sum_width(PRODUCT_WIDTH);
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC_SHIFT - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(PIXEL_MAX);

    logic [PRODUCT_WIDTH-2:0] w_ip [4];
    logic [WEIGHT_W-1:0]      w_v [4];
    logic [3:0]               w_ips;
    logic signed [TW-1:0]     w_term [4];
    logic signed [TW-1:0]     r_term [4];
    logic signed [SW-1:0]     w_sum, r_sum, w_round, w_r;
    logic                     w_en1, w_en2, w_en3;
    logic                     r_v1, r_v2, r_v3;
    logic                     w_neg, w_over, r_clamp;
    logic [7:0]               w_pix, r_pixel;
    logic [15:0]              r_cnt;

    assign w_ip  = '{ip1, ip2, ip3, ip4};
    assign w_v   = '{v1, v2, v3, v4};
    assign w_ips = {ip_sign4, ip_sign3, ip_sign2, ip_sign1};

    for (genvar g = 0; g < 4; g++) begin : g_term
        bicubic_sm_term #(.PRODUCT_WIDTH(PRODUCT_WIDTH)) u_term (
            .i_ip     (w_ip[g]),
            .i_ip_sign(w_ips[g]),
            .i_w      (w_v[g]),
            .i_w_sign (v_sign[g]),
            .o_term   (w_term[g])
        );
    end

    // A stage may load when empty or when its successor takes its contents.
    assign w_en3    = !r_v3 || out_ready;
    assign w_en2    = !r_v2 || w_en3;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 4; i++)
            w_sum = w_sum + {{(SW-TW){r_term[i][TW-1]}}, r_term[i]};
    end

    assign w_round = r_sum + HALF;
    assign w_r     = w_round >>> FRAC_SHIFT;
    assign w_neg   = w_r[SW-1];
    assign w_over  = !w_neg && (w_r > MAXV);
    assign w_pix   = w_neg ? 8'd0 : w_over ? 8'(PIXEL_MAX) : w_r[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            for (int i = 0; i < 4; i++) r_term[i] <= '0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) r_term <= w_term;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_sum <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) r_sum <= w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_pixel <= '0;
            r_clamp <= 1'b0;
        end else if (w_en3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_pixel <= w_pix;
                r_clamp <= w_neg || w_over;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_v3 && out_ready && r_clamp && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
    end

    assign out_valid = r_v3;
    assign pixel     = r_pixel;
    assign clamp_cnt = r_cnt;
endmodule

// File: tb/tb_bicubic_vweight_accum.sv
// tb_bicubic_vweight_accum: directed vectors with hand-computed pixels, checked by a
// queue-based scoreboard monitor that also tracks stall stability and the clamp count.
module tb_bicubic_vweight_accum;
    typedef struct {
        logic [7:0] pix;
        logic       clamp;
        int         acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  v1, v2, v3, v4, v_sign;
    logic [30:0] ip1, ip2, ip3, ip4;
    logic        ip_sign1, ip_sign2, ip_sign3, ip_sign4;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pixel;
    logic [15:0] clamp_cnt;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic [15:0] exp_cnt = '0;

    bicubic_vweight_accum dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v_sign(v_sign),
        .ip1(ip1), .ip2(ip2), .ip3(ip3), .ip4(ip4),
        .ip_sign1(ip_sign1), .ip_sign2(ip_sign2), .ip_sign3(ip_sign3), .ip_sign4(ip_sign4),
        .out_valid(out_valid), .out_ready(out_ready), .pixel(pixel), .clamp_cnt(clamp_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always high, 1 = pattern 1,0,0,1, 2 = always low; changes just after posedge.
    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        logic       stall = 1'b0;
        logic [7:0] stall_pix = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_pixel", int'(pixel), int'(stall_pix));
            end
            if (out_ready) chk("in_ready_when_out_ready", int'(in_ready), 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pixel %0d, expected no output", pixel);
                end else begin
                    e = q.pop_front();
                    chk("pixel", int'(pixel), int'(e.pix));
                    if (e.acc >= 0) chk("latency", cyc - e.acc, 2);
                    if (e.clamp && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            stall = out_valid && !out_ready;
            stall_pix = pixel;
        end
    end

    task automatic send(input logic [30:0] a, b, c, d, input logic [3:0] ips,
                        input logic [3:0] w1, w2, w3, w4, input logic [3:0] vs,
                        input logic [7:0] ep, input logic ec, input logic lat);
        int n = 0;
        exp_t e;
        @(negedge clk);
        {ip1, ip2, ip3, ip4} = {a, b, c, d};
        {ip_sign4, ip_sign3, ip_sign2, ip_sign1} = ips;
        {v1, v2, v3, v4} = {w1, w2, w3, w4};
        v_sign = vs;
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
        end else begin
            e.pix = ep;
            e.clamp = ec;
            e.acc = lat ? cyc + 1 : -1;
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pixels outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        {v1, v2, v3, v4, v_sign} = '0;
        {ip1, ip2, ip3, ip4} = '0;
        {ip_sign1, ip_sign2, ip_sign3, ip_sign4} = '0;
        #12;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_pixel", int'(pixel), 0);
        chk("reset_clamp_cnt", int'(clamp_cnt), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        send(100, 100, 100, 100, 4'b0000, 0, 8, 8, 0, 4'b0000, 8'd6, 1'b0, 1'b1);
        idle();
        drain();
        send(40000, 40000, 40000, 40000, 4'b0000, 1, 9, 9, 1, 4'b1001, 8'd255, 1'b1, 1'b1);
        idle();
        drain();
        chk("clamp_cnt_after_over", int'(clamp_cnt), 1);
        send(1000, 1000, 1000, 1000, 4'b1111, 0, 8, 8, 0, 4'b0000, 8'd0, 1'b1, 1'b1);
        idle();
        drain();
        chk("clamp_cnt_after_under", int'(clamp_cnt), 2);

        // Rounding and clamp boundaries, back to back.
        send(0, 8, 8, 0, 4'b0000, 0, 8, 8, 0, 4'b0000, 8'd1, 1'b0, 1'b0);
        send(0, 127, 0, 0, 4'b0000, 0, 1, 0, 0, 4'b0000, 8'd0, 1'b0, 1'b0);
        send(0, 4080, 4080, 0, 4'b0000, 0, 8, 8, 0, 4'b0000, 8'd255, 1'b0, 1'b0);
        send(0, 4096, 4096, 0, 4'b0000, 0, 8, 8, 0, 4'b0000, 8'd255, 1'b1, 1'b0);
        send(0, 128, 0, 0, 4'b0010, 0, 1, 0, 0, 4'b0000, 8'd0, 1'b0, 1'b0);
        send(0, 129, 0, 0, 4'b0010, 0, 1, 0, 0, 4'b0000, 8'd0, 1'b1, 1'b0);
        send(0, 800, 800, 0, 4'b0010, 0, 8, 8, 0, 4'b0010, 8'd50, 1'b0, 1'b0);
        idle();
        drain();
        chk("clamp_cnt_boundaries", int'(clamp_cnt), int'(exp_cnt));
        chk("clamp_cnt_boundaries_abs", int'(clamp_cnt), 4);

        // Stream of 8 under the 1,0,0,1 out_ready pattern: pixel p from ip = 16*p.
        rdy_mode = 1;
        for (int k = 1; k <= 8; k++)
            send(0, 31'(160 * k), 31'(160 * k), 0, 4'b0000, 0, 8, 8, 0, 4'b0000, 8'(10 * k), 1'b0, 1'b0);
        idle();
        drain();
        rdy_mode = 0;
        chk("clamp_cnt_stream", int'(clamp_cnt), 4);

        // Reset with three beats in flight and downstream stalled.
        rdy_mode = 2;
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++)
            send(40000, 40000, 40000, 40000, 4'b0000, 1, 9, 9, 1, 4'b1001, 8'd255, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        exp_cnt = '0;
        #1;
        chk("async_reset_out_valid", int'(out_valid), 0);
        chk("async_reset_clamp_cnt", int'(clamp_cnt), 0);
        chk("async_reset_in_ready", int'(in_ready), 1);
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        chk("reset_hold_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_stale_pixel", int'(out_valid), 0);

        // Saturate the clamp counter.
        for (int k = 0; k < 65535; k++)
            send(40000, 40000, 40000, 40000, 4'b0000, 1, 9, 9, 1, 4'b1001, 8'd255, 1'b1, 1'b0);
        idle();
        drain();
        chk("clamp_cnt_full", int'(clamp_cnt), 65535);
        send(1000, 1000, 1000, 1000, 4'b1111, 0, 8, 8, 0, 4'b0000, 8'd0, 1'b1, 1'b0);
        idle();
        drain();
        chk("clamp_cnt_saturated", int'(clamp_cnt), 65535);
        chk("clamp_cnt_model", int'(clamp_cnt), int'(exp_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
